muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. It sits between the register file read ports (RD1/RD2) and its write port (A3/WD/RFwr).
//  It latches both operands on start and stalls the single-cycle core while it computes.
//  It then presents one result with a one-cycle write strobe for the register file write-back mux.

---
 rtl/muldiv_unit_pkg.sv | 47 ++++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_iter_core.sv | 63 ++++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM
// state encoding, iteration constants and operand-decode helpers.
package muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNTW  = 6;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_hi;     // MULH*: upper product word; DIV family: remainder
  } op_cfg_t;

  function automatic op_cfg_t decode_op(input logic [2:0] f3);
    op_cfg_t c;
    c.is_div   = f3[2];
    c.sel_hi   = f3[2] ? f3[1] : (f3 != F3_MUL);
    c.a_signed = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    c.b_signed = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side handshake of the multiply/divide unit: decoded instruction and
// operands in, stall/result/write-back strobe out.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            wr_en;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  stall, busy, done, result, rd_out, wr_en
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output stall, busy, done, result, rd_out, wr_en
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration engine: 64-bit accumulator, iteration counter and one
// shift-add (multiply) or restoring-subtract (divide) step per cycle.
module muldiv_iter_core
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              last,
  output logic [2*XLEN-1:0] acc_step
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CNTW-1:0]   cnt_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     trial;

  assign last = (cnt_q == CNTW'(ITERS - 1));

  // Multiply keeps {partial, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left. Because the remainder is
  // always below the divisor, the 33-bit trial's MSB is the borrow.
  always_comb begin
    mul_sum  = '0;
    rem_sh   = '0;
    trial    = '0;
    acc_step = acc_q;
    if (is_div) begin
      rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      trial  = rem_sh - {1'b0, opnd_q};
      if (trial[XLEN]) begin
        acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
      opnd_q <= is_div ? op_b : op_a;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q  <= acc_step;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: latches operands, stalls the core,
// and returns one result with a single-cycle register-file write strobe.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched when it is seen
// ST_PREP | abs()/sign capture, special-case detect, load iteration core
// ST_CALC | 32 radix-2 iterations
// ST_DONE | result valid, done/wr_en pulse, core released
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  muldiv_unit_if.slave bus
);

  state_e            state_q;
  state_e            state_nxt;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;

  op_cfg_t           cfg;
  logic              sa;
  logic              sb;
  logic              div0;
  logic              ovf;
  logic              special;
  logic              neg_prep;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   part;
  logic [XLEN-1:0]   calc_val;
  logic [2*XLEN-1:0] prod_fix;
  logic [2*XLEN-1:0] acc_step;

  logic              stall_c;
  logic              latch_ops;
  logic              core_load;
  logic              core_step;
  logic              core_last;

  muldiv_iter_core u_core (
    .clk      (clk),
    .rstn     (rstn),
    .load     (core_load),
    .step     (core_step),
    .is_div   (cfg.is_div),
    .op_a     (abs_a),
    .op_b     (abs_b),
    .last     (core_last),
    .acc_step (acc_step)
  );

  always_comb begin
    cfg         = decode_op(f3_q);
    sa          = cfg.a_signed & a_q[XLEN-1];
    sb          = cfg.b_signed & b_q[XLEN-1];
    abs_a       = abs_val(a_q, cfg.a_signed);
    abs_b       = abs_val(b_q, cfg.b_signed);
    neg_prep    = (cfg.is_div && cfg.sel_hi) ? sa : (sa ^ sb);
    div0        = cfg.is_div && (b_q == '0);
    ovf         = cfg.is_div && cfg.a_signed &&
                  (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    special     = div0 || ovf;
    special_val = '0;
    if (div0) begin
      special_val = cfg.sel_hi ? a_q : '1;
    end else if (!cfg.sel_hi) begin
      special_val = {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Final value taken straight from the last step so it is registered on
  // the same edge that enters ST_DONE.
  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    part     = cfg.sel_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    calc_val = '0;
    if (cfg.is_div) begin
      calc_val = neg_q ? -part : part;
    end else begin
      calc_val = cfg.sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_nxt = state_q;
    stall_c   = 1'b0;
    latch_ops = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = bus.start;
        if (bus.start) begin
          latch_ops = 1'b1;
          state_nxt = ST_PREP;
        end
      end
      ST_PREP: begin
        stall_c = 1'b1;
        if (special) begin
          state_nxt = ST_DONE;
        end else begin
          core_load = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        stall_c   = 1'b1;
        core_step = 1'b1;
        if (core_last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      if (latch_ops) begin
        f3_q <= bus.funct3;
        a_q  <= bus.rs1_val;
        b_q  <= bus.rs2_val;
        rd_q <= bus.rd_in;
      end
      if (state_q == ST_PREP) neg_q <= neg_prep;
      if (state_q == ST_PREP && special) begin
        result_q <= special_val;
      end else if (state_q == ST_CALC && core_last) begin
        result_q <= calc_val;
      end
      busy_q  <= (state_nxt == ST_PREP) || (state_nxt == ST_CALC);
      done_q  <= (state_nxt == ST_DONE);
      wr_en_q <= (state_nxt == ST_DONE) && (rd_q != '0);
    end
  end

  assign bus.stall  = rstn & stall_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
  assign bus.wr_en  = wr_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued at issue
// and popped when done is seen.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0]        up;
    logic signed [31:0] a_s, b_s, q;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    a_s = a;
    b_s = b;
    up  = {32'd0, a} * {32'd0, b};
    model = '0;
    case (f3)
      3'b000: model = up[31:0];
      3'b001: begin p = sa * sb; model = p[63:32]; end
      3'b010: begin p = sa * ub; model = p[63:32]; end
      3'b011: model = up[63:32];
      3'b100: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
        else begin q = a_s / b_s; model = q; end
      end
      3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
        else begin q = a_s % b_s; model = q; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    exp_t e;
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    e.res = res;
    e.rd  = rd;
    e.wr  = (rd != 5'd0);
    e.lat = lat;
    sbq.push_back(e);
  endtask

  // Counts cycles from the start-sampled cycle to done; scrambles operands
  // after the first edge since the unit must not re-read them.
  task automatic wait_done(output int lat, output int stalls, output bit to);
    lat = 0;
    stalls = 0;
    #1;
    if (bus.stall) stalls++;
    do begin
      @(posedge clk); #1;
      lat++;
      bus.rs1_val = $urandom;
      bus.rs2_val = $urandom;
      if (!bus.done && bus.stall) stalls++;
    end while (!bus.done && lat < 80);
    to = !bus.done;
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    bus.start   = 1'b1;
    bus.funct3  = F3_DIV;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'd3;
    bus.rd_in   = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd_out got=%0d want=0", bus.rd_out); end
    bus.start = 1'b0;
    rstn      = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_mul();
    logic [2:0]  f3s [4] = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2};
    logic [31:0] rs  [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat, stalls;
    bit to;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(5 + i), rs[i], 34);
      wait_done(lat, stalls, to);
      e = sbq.pop_front();
      total++; if (to) begin bad++; $display("FAIL mul_timeout[%0d] no done within %0d cycles", i, lat); end
      total++; if (bus.result !== e.res) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, bus.result, e.res); end
      total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL mul_wr_en[%0d] got=%b want=%b", i, bus.wr_en, e.wr); end
      total++; if (bus.rd_out !== e.rd) begin bad++; $display("FAIL mul_rd_out[%0d] got=%0d want=%0d", i, bus.rd_out, e.rd); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      total++; if (stalls != e.lat) begin bad++; $display("FAIL mul_stall_cycles[%0d] got=%0d want=%0d", i, stalls, e.lat); end
      bus.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3s [6] = '{F3_DIV, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] as  [6] = '{32'd20, 32'd20, 32'd20, 32'd20, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] rs  [6] = '{32'hFFFF_FFFF, 32'd20, 32'hFFFF_FFFF, 32'd20, 32'h8000_0000, 32'd0};
    int lat, stalls;
    bit to;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(10 + i), rs[i], 2);
      wait_done(lat, stalls, to);
      e = sbq.pop_front();
      total++; if (to) begin bad++; $display("FAIL spec_timeout[%0d] no done within %0d cycles", i, lat); end
      total++; if (bus.result !== e.res) begin bad++; $display("FAIL spec_result[%0d] got=%h want=%h", i, bus.result, e.res); end
      total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL spec_wr_en[%0d] got=%b want=%b", i, bus.wr_en, e.wr); end
      total++; if (bus.rd_out !== e.rd) begin bad++; $display("FAIL spec_rd_out[%0d] got=%0d want=%0d", i, bus.rd_out, e.rd); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL spec_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      total++; if (stalls != e.lat) begin bad++; $display("FAIL spec_stall_cycles[%0d] got=%0d want=%0d", i, stalls, e.lat); end
      bus.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_signed();
    logic [2:0]  f3s [6] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] rs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1, 32'hFFFF_FFFD, 32'd1};
    int lat, stalls;
    bit to;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(20 + i), rs[i], 34);
      wait_done(lat, stalls, to);
      e = sbq.pop_front();
      total++; if (to) begin bad++; $display("FAIL div_timeout[%0d] no done within %0d cycles", i, lat); end
      total++; if (bus.result !== e.res) begin bad++; $display("FAIL div_result[%0d] got=%h want=%h", i, bus.result, e.res); end
      total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL div_wr_en[%0d] got=%b want=%b", i, bus.wr_en, e.wr); end
      total++; if (bus.rd_out !== e.rd) begin bad++; $display("FAIL div_rd_out[%0d] got=%0d want=%0d", i, bus.rd_out, e.rd); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      bus.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    int dones = 0;
    int wrs   = 0;
    bus.start   = 1'b1;
    bus.funct3  = F3_DIV;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    bus.rd_in   = 5'd3;
    repeat (11) begin @(posedge clk); #1; end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midop_busy_before got=%b want=1", bus.busy); end
    rstn = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midop_stall_forced got=%b want=0", bus.stall); end
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%b want=0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midop_stall got=%b want=0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midop_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL midop_result got=%h want=0", bus.result); end
    rstn      = 1'b1;
    bus.start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
      if (bus.wr_en) wrs++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midop_no_done got=%0d want=0", dones); end
    total++; if (wrs != 0) begin bad++; $display("FAIL midop_no_wr_en got=%0d want=0", wrs); end
  endtask

  task automatic test_back_to_back();
    int lat, stalls;
    bit to;
    exp_t e;
    issue(F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 34);
    wait_done(lat, stalls, to);
    e = sbq.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b_first_timeout no done within %0d cycles", lat); end
    total++; if (bus.result !== e.res) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", bus.result, e.res); end
    total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL b2b_rd0_wr_en got=%b want=%b", bus.wr_en, e.wr); end
    issue(F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b want=0", bus.stall); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_single_pulse got=%b want=0", bus.done); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_idle_accept got=%b want=1", bus.stall); end
    wait_done(lat, stalls, to);
    e = sbq.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b_second_timeout no done within %0d cycles", lat); end
    total++; if (bus.result !== e.res) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", bus.result, e.res); end
    total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL b2b_second_wr_en got=%b want=%b", bus.wr_en, e.wr); end
    total++; if (bus.rd_out !== e.rd) begin bad++; $display("FAIL b2b_second_rd_out got=%0d want=%0d", bus.rd_out, e.rd); end
    total++; if (lat != e.lat) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, e.lat); end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          sp;
    int lat, stalls;
    bit to;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      if (i == 1) begin f3 = F3_REM; b = 32'd0; end
      if (i == 3) begin f3 = F3_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 5) b = 32'($urandom_range(1, 15));
      sp = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      issue(f3, a, b, rd, model(f3, a, b), sp ? 2 : 34);
      wait_done(lat, stalls, to);
      e = sbq.pop_front();
      total++; if (to) begin bad++; $display("FAIL rand_timeout[%0d] no done within %0d cycles", i, lat); end
      total++; if (bus.result !== e.res) begin bad++; $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, bus.result, e.res); end
      total++; if (bus.wr_en !== e.wr) begin bad++; $display("FAIL rand_wr_en[%0d] got=%b want=%b", i, bus.wr_en, e.wr); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      bus.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_special();
    test_div_signed();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
